i2s_tx_sequencer: RTL and testbench
===================================

Name: i2s_tx_sequencer

Overview:
- Sequences 24-bit stereo sample transmission onto the I2S serial data line.
- Uses the SCLK/LRCLK edge strobes from the board's clock divider: SCLK = MCLK/8, LRCLK = MCLK/512, so there are 32 SCLK periods per channel.
- Buffers up to two stereo pairs from the upstream demodulator through a valid/ready handshake.
- Loads the shifter on frame boundaries, handles underrun, and keeps SDATA launched on the same MCLK edge that SCLK falls.

Parameters:
SAMPLE_W, 24, bits per channel sample, transmitted MSB first
SLOTS_PER_CH, 32, SCLK periods per LRCLK half-period; must be >= SAMPLE_W+1
BUF_DEPTH, 2, stereo-pair buffer entries; power of two

Ports:
MCLK  in  1  master clock; all logic on posedge
reset_n  in  1  asynchronous, active-low reset
enable  in  1  transmit enable, level sensitive
next_sclk_fall  in  1  one-MCLK strobe: SCLK falls on the next MCLK edge
next_lrclk_rise  in  1  one-MCLK strobe: LRCLK rises next edge (right channel starts)
next_lrclk_fall  in  1  one-MCLK strobe: LRCLK falls next edge (left channel starts)
sample_l  in  SAMPLE_W  left sample, two's complement
sample_r  in  SAMPLE_W  right sample, two's complement
sample_valid  in  1  upstream pair valid
sample_ready  out  1  buffer can accept a pair
SDATA  out  1  serial data, registered
underrun  out  1  one-MCLK pulse when a left frame starts with an empty buffer
underrun_count  out  8  saturating count of underruns
active  out  1  high in LEFT/RIGHT states

Behaviour:
- Reset (reset_n low, asynchronous): SDATA=0, sample_ready=0, underrun=0, underrun_count=0, active=0, buffer empty, state=IDLE, slot counter=0.
- Buffer: FIFO of {sample_l, sample_r}, BUF_DEPTH entries.
  - sample_ready = enable && !full, registered from next-state occupancy.
  - Push on sample_valid && sample_ready.
  - Push and pop in the same cycle keep occupancy unchanged.
  - No push is possible when full.
- States:
  - IDLE: SDATA=0. Go to SYNC when enable=1.
  - SYNC: SDATA=0. Go to LEFT when next_lrclk_fall. If the buffer is non-empty, pop the pair into shift_l/shift_r. If empty, load zeros, pulse underrun, and increment underrun_count, saturating at 255.
  - LEFT: shift shift_l. Go to RIGHT on next_lrclk_rise.
  - RIGHT: shift shift_r. On next_lrclk_fall, go to LEFT with the same load/underrun rule as SYNC.
  - enable=0 in any state: go to IDLE next cycle. SDATA=0, buffer flushed, and underrun_count held.
- Slot timing per channel:
  - The slot counter resets to 0 on each LRCLK strobe. It advances on each next_sclk_fall, and the output is updated on that same cycle.
  - Slot 0 (first SCLK fall at or after the LRCLK strobe) is the I2S one-bit delay: SDATA=0.
  - Slots 1..SAMPLE_W: SDATA = bits SAMPLE_W-1 down to 0.
  - Slots > SAMPLE_W: SDATA=0. The counter saturates at SLOTS_PER_CH-1.
- If an LRCLK strobe and next_sclk_fall coincide: the load happens first and that sclk fall is slot 0 of the new channel.
- Left and right always come from the same popped pair; the right half is never popped separately.
- Latency: a pair accepted before a next_lrclk_fall appears as the left MSB at slot 1 of that frame, i.e. 8 MCLK after the frame's slot 0.
- A strobe of the wrong polarity is ignored: next_lrclk_rise while in RIGHT, or next_lrclk_fall while in LEFT.
- Deassert reset_n mid-frame: all state is cleared, and transmission restarts via SYNC at the next full left frame.

Test Plan:
- Reset: hold reset_n=0 then release with enable=0 -> SDATA=0, sample_ready=0, underrun_count=0, state IDLE for 2000 MCLK.
- Single pair: enable=1, push L=24'hA5F00F, R=24'h123456 -> after the next LRCLK fall, SDATA is 0 on slot 0, then bits A5F00F MSB-first on slots 1..24, then 0 on slots 25..31. The right half carries 123456 with the same slot mapping.
- Backpressure: push 3 pairs back-to-back with no frames elapsed -> sample_ready drops after the 2nd accept; the 3rd is accepted the cycle after the first pop. All three pairs are transmitted in order.
- Underrun: enable=1 with no samples for 3 frames -> SDATA all zero, underrun pulses 3 times one MCLK each, underrun_count=3. Feeding 300 underruns -> underrun_count stays at 255.
- Mid-frame disable/reset: drop enable at slot 10 of the left channel -> SDATA=0 the next cycle and the buffer is empty. Re-enable -> output waits for the next LRCLK fall (no partial right frame). Repeat with a reset_n pulse mid-frame -> same result, and underrun_count=0.
- Strobe coincidence: drive next_lrclk_fall and next_sclk_fall in the same cycle -> that cycle is slot 0 and the MSB appears on the following next_sclk_fall.

Source files
------------

// File: rtl/i2s_tx_sequencer.sv
// I2S transmit sequencer: buffers stereo pairs and shifts them onto SDATA
// using the clock divider's SCLK/LRCLK edge strobes.
module i2s_tx_sequencer #(
  parameter int SAMPLE_W     = 24,
  parameter int SLOTS_PER_CH = 32,
  parameter int BUF_DEPTH    = 2
) (
  input  logic                MCLK,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                next_sclk_fall,
  input  logic                next_lrclk_rise,
  input  logic                next_lrclk_fall,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                SDATA,
  output logic                underrun,
  output logic [7:0]          underrun_count,
  output logic                active
);

  localparam int PAIR_W = 2 * SAMPLE_W;
  localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W  = $clog2(BUF_DEPTH + 1);
  localparam int SLOT_W = $clog2(SLOTS_PER_CH);

  localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(BUF_DEPTH);
  localparam logic [OCC_W-1:0]  OCC_ONE   = OCC_W'(1);
  localparam logic [OCC_W-1:0]  OCC_ZERO  = {OCC_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [SLOT_W-1:0] SLOT_ZERO = {SLOT_W{1'b0}};
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] SLOT_LSB  = SLOT_W'(SAMPLE_W);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS_PER_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_LEFT  = 2'd2,
    ST_RIGHT = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [PAIR_W-1:0]     fifo_mem_r [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s;
  logic [OCC_W-1:0]      occ_r, occ_s;
  logic                  push_s, pop_s, load_s, chan_start_s;
  logic [PAIR_W-1:0]     head_s;
  logic [SAMPLE_W-1:0]   shift_l_r, shift_l_s, shift_r_r, shift_r_s;
  logic [SLOT_W-1:0]     slot_r, slot_s, cur_slot_s;
  logic                  sdata_r, sdata_s;
  logic                  ready_r, und_r, und_s, active_r;
  logic [7:0]            und_cnt_r, und_cnt_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      ptr_inc = PTR_ZERO;
    end else begin
      ptr_inc = ptr + PTR_W'(1);
    end
  endfunction

  assign head_s         = fifo_mem_r[rd_ptr_r];
  assign sample_ready   = ready_r;
  assign SDATA          = sdata_r;
  assign underrun       = und_r;
  assign underrun_count = und_cnt_r;
  assign active         = active_r;

  // Channel sequencing: state transitions, frame loads and slot-driven serialisation.
  always_comb begin
    state_s      = state_r;
    load_s       = 1'b0;
    chan_start_s = 1'b0;
    pop_s        = 1'b0;
    shift_l_s    = shift_l_r;
    shift_r_s    = shift_r_r;
    slot_s       = slot_r;
    cur_slot_s   = slot_r;
    sdata_s      = sdata_r;
    und_s        = 1'b0;
    und_cnt_s    = und_cnt_r;
    if (!enable) begin
      state_s = ST_IDLE;
      sdata_s = 1'b0;
      slot_s  = SLOT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_SYNC;
          sdata_s = 1'b0;
        end
        ST_SYNC: begin
          sdata_s = 1'b0;
          if (next_lrclk_fall) begin
            state_s = ST_LEFT;
            load_s  = 1'b1;
          end else begin
            state_s = ST_SYNC;
          end
        end
        ST_LEFT: begin
          if (next_lrclk_rise) begin
            state_s      = ST_RIGHT;
            chan_start_s = 1'b1;
          end else begin
            state_s = ST_LEFT;
          end
        end
        ST_RIGHT: begin
          if (next_lrclk_fall) begin
            state_s = ST_LEFT;
            load_s  = 1'b1;
          end else begin
            state_s = ST_RIGHT;
          end
        end
        default: begin
          state_s = ST_IDLE;
          sdata_s = 1'b0;
        end
      endcase

      // A left frame always takes a whole pair; an empty buffer sends silence.
      if (load_s) begin
        chan_start_s = 1'b1;
        if (occ_r != OCC_ZERO) begin
          pop_s     = 1'b1;
          shift_l_s = head_s[PAIR_W-1:SAMPLE_W];
          shift_r_s = head_s[SAMPLE_W-1:0];
        end else begin
          shift_l_s = {SAMPLE_W{1'b0}};
          shift_r_s = {SAMPLE_W{1'b0}};
          und_s     = 1'b1;
          und_cnt_s = (und_cnt_r != 8'hFF) ? (und_cnt_r + 8'd1) : und_cnt_r;
        end
      end else begin
        pop_s = 1'b0;
      end

      if ((state_s == ST_LEFT) || (state_s == ST_RIGHT)) begin
        cur_slot_s = chan_start_s ? SLOT_ZERO : slot_r;
        slot_s     = cur_slot_s;
        if (next_sclk_fall) begin
          if ((cur_slot_s >= SLOT_ONE) && (cur_slot_s <= SLOT_LSB)) begin
            if (state_s == ST_LEFT) begin
              sdata_s   = shift_l_s[SAMPLE_W-1];
              shift_l_s = {shift_l_s[SAMPLE_W-2:0], 1'b0};
            end else begin
              sdata_s   = shift_r_s[SAMPLE_W-1];
              shift_r_s = {shift_r_s[SAMPLE_W-2:0], 1'b0};
            end
          end else begin
            sdata_s = 1'b0;
          end
          slot_s = (cur_slot_s == SLOT_LAST) ? SLOT_LAST : (cur_slot_s + SLOT_ONE);
        end else begin
          slot_s = cur_slot_s;
        end
      end else begin
        slot_s = SLOT_ZERO;
      end
    end
  end

  // Pair buffer bookkeeping; disabling flushes it.
  always_comb begin
    push_s   = 1'b0;
    wr_ptr_s = wr_ptr_r;
    rd_ptr_s = rd_ptr_r;
    occ_s    = occ_r;
    if (!enable) begin
      wr_ptr_s = PTR_ZERO;
      rd_ptr_s = PTR_ZERO;
      occ_s    = OCC_ZERO;
    end else begin
      push_s   = sample_valid && ready_r && (occ_r != OCC_FULL);
      wr_ptr_s = push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
      rd_ptr_s = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   occ_s = occ_r + OCC_ONE;
        2'b01:   occ_s = occ_r - OCC_ONE;
        default: occ_s = occ_r;
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      wr_ptr_r  <= PTR_ZERO;
      rd_ptr_r  <= PTR_ZERO;
      occ_r     <= OCC_ZERO;
      shift_l_r <= {SAMPLE_W{1'b0}};
      shift_r_r <= {SAMPLE_W{1'b0}};
      slot_r    <= SLOT_ZERO;
      sdata_r   <= 1'b0;
      ready_r   <= 1'b0;
      und_r     <= 1'b0;
      und_cnt_r <= 8'd0;
      active_r  <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        fifo_mem_r[i] <= {PAIR_W{1'b0}};
      end
    end else begin
      state_r   <= state_s;
      wr_ptr_r  <= wr_ptr_s;
      rd_ptr_r  <= rd_ptr_s;
      occ_r     <= occ_s;
      shift_l_r <= shift_l_s;
      shift_r_r <= shift_r_s;
      slot_r    <= slot_s;
      sdata_r   <= sdata_s;
      ready_r   <= enable && (occ_s != OCC_FULL);
      und_r     <= und_s;
      und_cnt_r <= und_cnt_s;
      active_r  <= (state_s == ST_LEFT) || (state_s == ST_RIGHT);
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {sample_l, sample_r};
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Bench for i2s_tx_sequencer: frame-level reference model checked every MCLK,
// a vector table of whole frames, and directed corner-case sequences.
module tb_i2s_tx_sequencer;

  logic        MCLK = 1'b0;
  logic        reset_n, enable, next_sclk_fall, next_lrclk_rise, next_lrclk_fall;
  logic [23:0] sample_l, sample_r;
  logic        sample_valid, sample_ready, SDATA, underrun, active;
  logic [7:0]  underrun_count;

  always #5 MCLK = ~MCLK;

  i2s_tx_sequencer dut (
    .MCLK(MCLK), .reset_n(reset_n), .enable(enable),
    .next_sclk_fall(next_sclk_fall), .next_lrclk_rise(next_lrclk_rise),
    .next_lrclk_fall(next_lrclk_fall), .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .SDATA(SDATA),
    .underrun(underrun), .underrun_count(underrun_count), .active(active)
  );

  typedef struct {
    logic        push;
    logic [23:0] l;
    logic [23:0] r;
    logic        exp_und;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  int sdiv = 8;
  int mdiv = 0;

  // Reference model: a queue of pairs plus frame position arithmetic.
  logic [47:0] q[$];
  logic        m_ready, m_armed, m_tx, m_und, m_sd, m_acc;
  logic [47:0] m_pair;
  int          m_cnt;

  logic [63:0] cur_frame = 64'd0;
  logic        und_latch = 1'b0;
  logic [63:0] frames_q[$];
  logic        und_q[$];
  int          und_pulses = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got timeout expected event at %0t", name, $time);
  endtask

  function automatic void model_clear();
    q.delete();
    m_ready = 1'b0; m_armed = 1'b0; m_tx = 1'b0; m_und = 1'b0;
    m_sd = 1'b0; m_acc = 1'b0; m_pair = 48'd0; m_cnt = 0;
  endfunction

  function automatic void model_step();
    int p, g, slot;
    logic [23:0] word;
    p = 64 * sdiv;
    m_acc = 1'b0;
    m_und = 1'b0;
    if (!enable) begin
      q.delete();
      m_tx = 1'b0; m_armed = 1'b0; m_ready = 1'b0;
    end else begin
      if (mdiv == p - 1 && (m_armed || m_tx)) begin
        if (q.size() > 0) begin
          m_pair = q.pop_front();
        end else begin
          m_pair = 48'd0;
          m_und = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
        m_tx = 1'b1;
      end
      if (sample_valid && m_ready) begin
        q.push_back({sample_l, sample_r});
        m_acc = 1'b1;
      end
      m_armed = 1'b1;
      m_ready = (q.size() < 2);
    end
    m_sd = 1'b0;
    if (m_tx) begin
      g = ((mdiv + 1) % p) / sdiv;
      slot = g % 32;
      word = (g >= 32) ? m_pair[23:0] : m_pair[47:24];
      if (slot >= 1 && slot <= 24) m_sd = word[24 - slot];
    end
  endfunction

  task automatic tick();
    int p;
    bit fall;
    p = 64 * sdiv;
    fall = ((mdiv % sdiv) == sdiv - 1);
    next_sclk_fall  = fall;
    next_lrclk_fall = (mdiv == p - 1);
    next_lrclk_rise = (mdiv == p / 2 - 1);
    @(posedge MCLK);
    if (!reset_n) model_clear();
    else model_step();
    #1;
    chk("sdata", SDATA, m_sd);
    chk("sample_ready", sample_ready, m_ready);
    chk("underrun", underrun, m_und);
    chk("underrun_count", underrun_count, m_cnt[7:0]);
    chk("active", active, m_tx);
    if (underrun) und_pulses++;
    if (mdiv == p - 1) und_latch = underrun;
    if (fall) cur_frame = {cur_frame[62:0], SDATA};
    if (mdiv == p - 1 - sdiv) begin
      frames_q.push_back(cur_frame);
      und_q.push_back(und_latch);
    end
    mdiv = (mdiv + 1) % p;
  endtask

  task automatic goto(input int m);
    for (int i = 0; i < 2000 && mdiv != m; i++) tick();
    if (mdiv != m) timeout("goto");
  endtask

  task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
    bit done;
    done = 0;
    sample_l = l;
    sample_r = r;
    sample_valid = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) begin
      tick();
      done = m_acc;
    end
    sample_valid = 1'b0;
    if (!done) timeout("push_accept");
  endtask

  task automatic wait_frame(output logic [63:0] f, output logic u);
    for (int i = 0; i < 1200 && frames_q.size() == 0; i++) tick();
    if (frames_q.size() == 0) begin
      timeout("frame");
      f = 64'd0;
      u = 1'b0;
    end else begin
      f = frames_q.pop_front();
      u = und_q.pop_front();
    end
  endtask

  function automatic logic [63:0] frame_of(input logic [23:0] l, input logic [23:0] r);
    return {1'b0, l, 7'd0, 1'b0, r, 7'd0};
  endfunction

  initial begin
    vec_t        vecs[4];
    logic [63:0] f;
    logic        u;
    logic [23:0] bp_l[3];
    logic [23:0] bp_r[3];
    int          acc_m, base, off;

    vecs[0] = '{push: 1'b1, l: 24'hA5F00F, r: 24'h123456, exp_und: 1'b0};
    vecs[1] = '{push: 1'b0, l: 24'h000000, r: 24'h000000, exp_und: 1'b1};
    vecs[2] = '{push: 1'b1, l: 24'h800001, r: 24'h7FFFFE, exp_und: 1'b0};
    vecs[3] = '{push: 1'b1, l: 24'hFFFFFF, r: 24'h000000, exp_und: 1'b0};
    bp_l = '{24'h111111, 24'h222222, 24'h333333};
    bp_r = '{24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC};

    reset_n = 1'b0; enable = 1'b0; sample_valid = 1'b0;
    sample_l = 24'd0; sample_r = 24'd0;
    next_sclk_fall = 1'b0; next_lrclk_rise = 1'b0; next_lrclk_fall = 1'b0;
    model_clear();

    // Reset, then idle with enable low.
    repeat (5) tick();
    reset_n = 1'b1;
    repeat (2000) tick();
    chk("reset_sdata", SDATA, 1'b0);
    chk("reset_ready", sample_ready, 1'b0);
    chk("reset_count", underrun_count, 8'd0);
    chk("reset_active", active, 1'b0);

    // Whole-frame vectors, including the coincident LRCLK/SCLK strobe at slot 0.
    enable = 1'b1;
    goto(504);
    frames_q.delete();
    und_q.delete();
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].push) push_pair(vecs[i].l, vecs[i].r);
      wait_frame(f, u);
      chk("vec_frame", f, frame_of(vecs[i].l, vecs[i].r));
      chk("vec_underrun", u, vecs[i].exp_und);
    end

    // Backpressure: three pairs back to back.
    goto(16);
    push_pair(bp_l[0], bp_r[0]);
    chk("bp_ready_after_1", sample_ready, 1'b1);
    push_pair(bp_l[1], bp_r[1]);
    chk("bp_ready_after_2", sample_ready, 1'b0);
    push_pair(bp_l[2], bp_r[2]);
    acc_m = (mdiv + 511) % 512;
    chk("bp_third_accept_phase", acc_m, 0);
    wait_frame(f, u);
    for (int i = 0; i < 3; i++) begin
      wait_frame(f, u);
      chk("bp_frame", f, frame_of(bp_l[i], bp_r[i]));
    end

    // Underrun for three frames.
    base = underrun_count;
    und_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      wait_frame(f, u);
      chk("und_frame_zero", f, 64'd0);
    end
    chk("und_pulses", und_pulses, 3);
    chk("und_count", underrun_count, base + 3);

    // Disable mid left frame with a pair still buffered.
    push_pair(24'hC0FFEE, 24'hBEEF01);
    push_pair(24'h0F0F0F, 24'hF0F0F0);
    goto(83);
    enable = 1'b0;
    tick();
    chk("dis_sdata", SDATA, 1'b0);
    chk("dis_active", active, 1'b0);
    goto(100);
    enable = 1'b1;
    goto(300);
    chk("reen_no_right_active", active, 1'b0);
    chk("reen_no_right_sdata", SDATA, 1'b0);
    goto(511);
    tick();
    chk("reen_flushed_underrun", underrun, 1'b1);

    // Reset pulse mid left frame with a pair buffered.
    push_pair(24'h13579B, 24'h2468AC);
    goto(83);
    reset_n = 1'b0;
    #2;
    chk("rst_sdata", SDATA, 1'b0);
    chk("rst_count", underrun_count, 8'd0);
    chk("rst_ready", sample_ready, 1'b0);
    tick();
    reset_n = 1'b1;
    goto(300);
    chk("rst_no_right_active", active, 1'b0);
    goto(511);
    tick();
    chk("rst_flushed_underrun", underrun, 1'b1);
    chk("rst_count_after", underrun_count, 8'd1);

    // Saturation: 300+ underruns with a fast strobe pattern.
    enable = 1'b0;
    tick();
    sdiv = 1;
    mdiv = 0;
    enable = 1'b1;
    repeat (305 * 64) tick();
    chk("sat_count", underrun_count, 8'd255);
    enable = 1'b0;
    tick();
    sdiv = 8;
    mdiv = 0;

    // Randomised traffic with occasional disable windows and one reset.
    off = 0;
    for (int i = 0; i < 16000; i++) begin
      if (off > 0) begin
        off--;
        enable = 1'b0;
      end else begin
        enable = 1'b1;
        if ($urandom_range(0, 2999) == 0) off = $urandom_range(1, 40);
      end
      if (!sample_valid && $urandom_range(0, 199) == 0) begin
        sample_valid = 1'b1;
        sample_l = 24'($urandom);
        sample_r = 24'($urandom);
      end
      if (i == 8000) reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      if (m_acc) sample_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
